// File: rtl/if_stage_pipe.sv
// if_stage_pipe: pipelined instruction fetch with a variable-latency valid/ready imem port and a fetch queue
module if_stage_pipe #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int FQ_DEPTH = 4,
  parameter int MAX_OUT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_add4,
  output logic [31:0]     id_instr
);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int QW = $clog2(FQ_DEPTH + 1);
  logic [XLEN-1:0] fetch_pc;
  logic [OW-1:0] out_cnt, drop_cnt, live;
  logic [QW-1:0] fq_cnt;
  logic [XLEN-1:0] pend [MAX_OUT];
  logic [XLEN-1:0] pend_n [MAX_OUT];
  logic [XLEN-1:0] fq_pc [FQ_DEPTH];
  logic [XLEN-1:0] fq_pc_n [FQ_DEPTH];
  logic [31:0] fq_ins [FQ_DEPTH];
  logic [31:0] fq_ins_n [FQ_DEPTH];
  logic fire, rsp, drop, keep, pop;
  // live requests are the outstanding ones not already marked for squashing
  assign live = out_cnt - drop_cnt;
  assign imem_req_valid = !rst && !redirect_valid && out_cnt < OW'(MAX_OUT) &&
                          32'(live) + 32'(fq_cnt) < FQ_DEPTH;
  assign imem_req_addr = fetch_pc;
  assign fire = imem_req_valid && imem_req_ready;
  assign rsp = imem_rsp_valid && out_cnt != '0;
  assign drop = rsp && drop_cnt != '0;
  assign keep = rsp && drop_cnt == '0;
  assign id_valid = !rst && fq_cnt != '0;
  assign pop = id_valid && id_ready;
  assign id_pc = id_valid ? fq_pc[0] : '0;
  assign id_pc_add4 = id_valid ? fq_pc[0] + XLEN'(4) : '0;
  assign id_instr = id_valid ? fq_ins[0] : '0;
  // both queues are shift registers with the head at index 0
  always_comb begin
    pend_n = pend;
    fq_pc_n = fq_pc;
    fq_ins_n = fq_ins;
    for (int i = 0; i < MAX_OUT - 1; i++) pend_n[i] = keep ? pend[i + 1] : pend_n[i];
    for (int i = 0; i < MAX_OUT; i++)
      pend_n[i] = (fire && i == 32'(live) - 32'(keep)) ? fetch_pc : pend_n[i];
    for (int i = 0; i < FQ_DEPTH - 1; i++) begin
      fq_pc_n[i] = pop ? fq_pc[i + 1] : fq_pc_n[i];
      fq_ins_n[i] = pop ? fq_ins[i + 1] : fq_ins_n[i];
    end
    for (int i = 0; i < FQ_DEPTH; i++) begin
      fq_pc_n[i] = (keep && i == 32'(fq_cnt) - 32'(pop)) ? pend[0] : fq_pc_n[i];
      fq_ins_n[i] = (keep && i == 32'(fq_cnt) - 32'(pop)) ? imem_rsp_data : fq_ins_n[i];
    end
  end
  always_ff @(posedge clk) begin
    pend <= pend_n;
    fq_pc <= fq_pc_n;
    fq_ins <= fq_ins_n;
  end
  // a redirect turns every still-outstanding request into one owed a discarded response
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      out_cnt <= '0;
      drop_cnt <= '0;
      fq_cnt <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~XLEN'(3);
      out_cnt <= out_cnt - OW'(rsp);
      drop_cnt <= out_cnt - OW'(rsp);
      fq_cnt <= '0;
    end else begin
      fetch_pc <= fire ? fetch_pc + XLEN'(4) : fetch_pc;
      out_cnt <= out_cnt + OW'(fire) - OW'(rsp);
      drop_cnt <= drop_cnt - OW'(drop);
      fq_cnt <= fq_cnt + QW'(keep) - QW'(pop);
    end
  end
endmodule

// File: tb/tb_if_stage_pipe.sv
// tb_if_stage_pipe: directed scenarios against a latency-configurable in-order imem model
module tb_if_stage_pipe;
  logic clk = 1'b0, rst = 1'b1, redirect_valid = 1'b0, imem_req_ready = 1'b1;
  logic imem_rsp_valid = 1'b0, id_ready = 1'b1, spurious = 1'b0, real_rsp = 1'b0;
  logic [31:0] redirect_pc = '0, imem_rsp_data = '0;
  logic imem_req_valid, id_valid;
  logic [31:0] imem_req_addr, id_pc, id_pc_add4, id_instr;
  localparam logic [31:0] K = 32'hDEAD0000;
  typedef struct { logic [31:0] addr; int due; } req_t;
  req_t mq[$];
  logic [31:0] reqs[$], gpc[$], gad[$], gin[$];
  int gcy[$];
  int checks = 0, errors = 0, lat = 1, cyc = 0, mcyc = 0;

  if_stage_pipe dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_pc_add4(id_pc_add4), .id_instr(id_instr)
  );

  always #5 clk = ~clk;

  // imem model: in-order, fixed latency lat, instruction word = addr ^ K
  always @(posedge clk) begin
    if (rst) mq.delete();
    else begin
      if (real_rsp) void'(mq.pop_front());
      if (imem_req_valid && imem_req_ready) mq.push_back('{imem_req_addr, cyc + lat});
    end
    cyc++;
    #1;
    real_rsp = mq.size() > 0 && mq[0].due <= cyc;
    imem_rsp_valid = real_rsp || spurious;
    imem_rsp_data = real_rsp ? mq[0].addr ^ K : 32'hFFFF_FFFF;
  end

  always @(posedge clk) begin
    mcyc++;
    if (!rst && imem_req_valid && imem_req_ready) reqs.push_back(imem_req_addr);
    if (!rst && id_valid && id_ready) begin
      gpc.push_back(id_pc); gad.push_back(id_pc_add4); gin.push_back(id_instr); gcy.push_back(mcyc);
    end
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; redirect_valid = 1'b0; spurious = 1'b0; imem_req_ready = 1'b1; id_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    reqs.delete(); gpc.delete(); gad.delete(); gin.delete(); gcy.delete();
  endtask

  task automatic test_reset();
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_id_valid: got %b want 0", id_valid); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL rst_id_pc: got %h want 0", id_pc); end
    checks++; if (id_pc_add4 !== 32'h0) begin errors++; $display("FAIL rst_id_pc_add4: got %h want 0", id_pc_add4); end
    checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL rst_id_instr: got %h want 0", id_instr); end
    lat = 1;
    do_reset();
    #1;
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL rst_release_valid: got %b want 1", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL rst_release_addr: got %h want 0", imem_req_addr); end
  endtask

  task automatic test_stream();
    lat = 1;
    do_reset();
    @(negedge clk); #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL t1_no_bypass: got %b want 0", id_valid); end
    @(negedge clk); #1;
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL t1_first_valid: got %b want 1", id_valid); end
    checks++; if (id_pc_add4 !== 32'h4) begin errors++; $display("FAIL t1_first_add4: got %h want 4", id_pc_add4); end
    checks++; if (id_instr !== K) begin errors++; $display("FAIL t1_first_instr: got %h want %h", id_instr, K); end
    repeat (10) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      checks++; if (reqs[i] !== 32'(4 * i)) begin errors++; $display("FAIL t1_req_addr[%0d]: got %h want %h", i, reqs[i], 32'(4 * i)); end
      checks++; if (gpc[i] !== 32'(4 * i)) begin errors++; $display("FAIL t1_id_pc[%0d]: got %h want %h", i, gpc[i], 32'(4 * i)); end
      checks++; if (gad[i] !== 32'(4 * i + 4)) begin errors++; $display("FAIL t1_id_add4[%0d]: got %h want %h", i, gad[i], 32'(4 * i + 4)); end
      checks++; if (gin[i] !== (32'(4 * i) ^ K)) begin errors++; $display("FAIL t1_id_instr[%0d]: got %h want %h", i, gin[i], 32'(4 * i) ^ K); end
    end
    for (int i = 1; i < 6; i++) begin
      checks++; if (gcy[i] !== gcy[0] + i) begin errors++; $display("FAIL t1_back_to_back[%0d]: got %0d want %0d", i, gcy[i], gcy[0] + i); end
    end
  endtask

  task automatic test_backpressure();
    lat = 1;
    do_reset();
    id_ready = 1'b0;
    repeat (10) @(negedge clk); #1;
    checks++; if (reqs.size() !== 4) begin errors++; $display("FAIL t2_req_count: got %0d want 4", reqs.size()); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL t2_req_stall: got %b want 0", imem_req_valid); end
    checks++; if (32'(dut.fq_cnt) !== 4) begin errors++; $display("FAIL t2_fq_cnt: got %0d want 4", dut.fq_cnt); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL t2_id_pc: got %h want 0", id_pc); end
    repeat (3) @(negedge clk); #1;
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL t2_hold_valid: got %b want 1", id_valid); end
    checks++; if (id_instr !== K) begin errors++; $display("FAIL t2_hold_instr: got %h want %h", id_instr, K); end
    checks++; if (reqs.size() !== 4) begin errors++; $display("FAIL t2_req_count_hold: got %0d want 4", reqs.size()); end
    @(negedge clk); id_ready = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      checks++; if (gpc[i] !== 32'(4 * i)) begin errors++; $display("FAIL t2_drain_pc[%0d]: got %h want %h", i, gpc[i], 32'(4 * i)); end
    end
    for (int i = 1; i < 4; i++) begin
      checks++; if (gcy[i] !== gcy[0] + i) begin errors++; $display("FAIL t2_drain_b2b[%0d]: got %0d want %0d", i, gcy[i], gcy[0] + i); end
    end
  endtask

  task automatic test_hold_and_spurious();
    lat = 1;
    do_reset();
    imem_req_ready = 1'b0; spurious = 1'b1;
    @(negedge clk); spurious = 1'b0;
    repeat (2) @(negedge clk); #1;
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL hold_valid: got %b want 1", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL hold_addr: got %h want 0", imem_req_addr); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL spurious_id_valid: got %b want 0", id_valid); end
    checks++; if (32'(dut.out_cnt) !== 0) begin errors++; $display("FAIL spurious_out_cnt: got %0d want 0", dut.out_cnt); end
    @(negedge clk); imem_req_ready = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (gpc[0] !== 32'h0) begin errors++; $display("FAIL spurious_pc0: got %h want 0", gpc[0]); end
    checks++; if (gpc[1] !== 32'h4) begin errors++; $display("FAIL spurious_pc1: got %h want 4", gpc[1]); end
  endtask

  task automatic test_redirect_stale();
    lat = 3;
    do_reset();
    @(negedge clk); @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL t3_no_req: got %b want 0", imem_req_valid); end
    checks++; if (32'(dut.out_cnt) !== 2) begin errors++; $display("FAIL t3_out_cnt: got %0d want 2", dut.out_cnt); end
    @(negedge clk); redirect_valid = 1'b0; #1;
    checks++; if (32'(dut.drop_cnt) !== 2) begin errors++; $display("FAIL t3_drop_cnt: got %0d want 2", dut.drop_cnt); end
    checks++; if (imem_req_addr !== 32'h100) begin errors++; $display("FAIL t3_new_addr: got %h want 100", imem_req_addr); end
    repeat (15) @(negedge clk); #1;
    checks++; if (32'(dut.drop_cnt) !== 0) begin errors++; $display("FAIL t3_drop_done: got %0d want 0", dut.drop_cnt); end
    checks++; if (reqs[2] !== 32'h100) begin errors++; $display("FAIL t3_req2: got %h want 100", reqs[2]); end
    checks++; if (gpc.size() < 3) begin errors++; $display("FAIL t3_pop_count: got %0d want >=3", gpc.size()); end
    for (int i = 0; i < gpc.size(); i++) begin
      checks++; if (gpc[i] !== 32'h100 + 32'(4 * i)) begin errors++; $display("FAIL t3_pc[%0d]: got %h want %h", i, gpc[i], 32'h100 + 32'(4 * i)); end
    end
  endtask

  task automatic test_redirect_coincident();
    logic [31:0] exp [7];
    exp = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h400, 32'h404, 32'h408};
    lat = 1;
    do_reset();
    repeat (5) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h400; #1;
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL t4_id_valid: got %b want 1", id_valid); end
    checks++; if (id_pc !== 32'hC) begin errors++; $display("FAIL t4_id_pc: got %h want c", id_pc); end
    checks++; if (32'(dut.out_cnt) !== 1) begin errors++; $display("FAIL t4_out_cnt: got %0d want 1", dut.out_cnt); end
    @(negedge clk); redirect_valid = 1'b0; #1;
    checks++; if (32'(dut.drop_cnt) !== 0) begin errors++; $display("FAIL t4_drop_cnt: got %0d want 0", dut.drop_cnt); end
    checks++; if (32'(dut.out_cnt) !== 0) begin errors++; $display("FAIL t4_out_cnt_after: got %0d want 0", dut.out_cnt); end
    checks++; if (imem_req_addr !== 32'h400) begin errors++; $display("FAIL t4_req_addr: got %h want 400", imem_req_addr); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL t4_flushed: got %b want 0", id_valid); end
    repeat (8) @(negedge clk);
    checks++; if (reqs[5] !== 32'h400) begin errors++; $display("FAIL t4_req5: got %h want 400", reqs[5]); end
    for (int i = 0; i < 7; i++) begin
      checks++; if (gpc[i] !== exp[i]) begin errors++; $display("FAIL t4_pc[%0d]: got %h want %h", i, gpc[i], exp[i]); end
    end
  endtask

  task automatic test_align_wrap();
    lat = 1;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h203; #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL t5_no_req: got %b want 0", imem_req_valid); end
    @(negedge clk); redirect_valid = 1'b0; #1;
    checks++; if (imem_req_addr !== 32'h200) begin errors++; $display("FAIL t5_align: got %h want 200", imem_req_addr); end
    @(negedge clk); #1;
    checks++; if (imem_req_addr !== 32'h204) begin errors++; $display("FAIL t5_next: got %h want 204", imem_req_addr); end
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    @(negedge clk); redirect_valid = 1'b0; #1;
    checks++; if (imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL t5_top: got %h want fffffffc", imem_req_addr); end
    @(negedge clk); #1;
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL t5_wrap: got %h want 0", imem_req_addr); end
    repeat (6) @(negedge clk);
    checks++; if (gpc[0] !== 32'h200) begin errors++; $display("FAIL t5_pc0: got %h want 200", gpc[0]); end
    checks++; if (gpc[1] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL t5_pc1: got %h want fffffffc", gpc[1]); end
    checks++; if (gad[1] !== 32'h0) begin errors++; $display("FAIL t5_add4_wrap: got %h want 0", gad[1]); end
    checks++; if (gin[1] !== (32'hFFFF_FFFC ^ K)) begin errors++; $display("FAIL t5_instr1: got %h want %h", gin[1], 32'hFFFF_FFFC ^ K); end
    checks++; if (gpc[2] !== 32'h0) begin errors++; $display("FAIL t5_pc2: got %h want 0", gpc[2]); end
    checks++; if (gpc[3] !== 32'h4) begin errors++; $display("FAIL t5_pc3: got %h want 4", gpc[3]); end
  endtask

  task automatic test_reset_midstream();
    lat = 1;
    do_reset();
    id_ready = 1'b0;
    repeat (8) @(negedge clk); #1;
    checks++; if (32'(dut.fq_cnt) !== 4) begin errors++; $display("FAIL t6_full: got %0d want 4", dut.fq_cnt); end
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL t6_rst_id_valid: got %b want 0", id_valid); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL t6_rst_id_pc: got %h want 0", id_pc); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL t6_rst_req_valid: got %b want 0", imem_req_valid); end
    @(negedge clk); #1;
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL t6_req_addr: got %h want 0", imem_req_addr); end
    checks++; if (32'(dut.out_cnt) !== 0) begin errors++; $display("FAIL t6_out_cnt: got %0d want 0", dut.out_cnt); end
    checks++; if (32'(dut.drop_cnt) !== 0) begin errors++; $display("FAIL t6_drop_cnt: got %0d want 0", dut.drop_cnt); end
    checks++; if (32'(dut.fq_cnt) !== 0) begin errors++; $display("FAIL t6_fq_cnt: got %0d want 0", dut.fq_cnt); end
    @(negedge clk); rst = 1'b0; id_ready = 1'b1;
    reqs.delete(); gpc.delete(); gad.delete(); gin.delete(); gcy.delete();
    #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL t6_release_id_valid: got %b want 0", id_valid); end
    repeat (6) @(negedge clk);
    checks++; if (gpc[0] !== 32'h0) begin errors++; $display("FAIL t6_pc0: got %h want 0", gpc[0]); end
    checks++; if (gpc[1] !== 32'h4) begin errors++; $display("FAIL t6_pc1: got %h want 4", gpc[1]); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_hold_and_spurious();
    test_redirect_stale();
    test_redirect_coincident();
    test_align_wrap();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
